i2c_target: RTL

//   Bus-side I2C target (slave) answering one 7-bit address; the other end of the
//   I2C controller state machine (start/stop/byte phases). Oversamples SCL/SDA on the

---
 rtl/i2c_target.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target answering a single 7-bit address: oversampled SCL/SDA, START/STOP
// detection, address match, ACK generation and byte shifting to/from the fabric.
//
// state      | meaning
// S_IDLE     | ignore bus until START
// S_ADDR     | shifting address + R/W bit
// S_ADDR_ACK | driving ACK for our address
// S_RX       | shifting a write byte in
// S_RX_ACK   | driving ACK for a received byte
// S_TX       | driving a read byte out
// S_TX_ACK   | sampling controller ACK/NACK
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda;
  logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [6:0]  r_sr;
  logic [6:0]  r_tx_sr;
  logic        r_rw;
  logic        r_ack_ph;
  logic        r_first;
  logic        r_sda_oe, r_rx_valid, r_rx_first, r_tx_req, r_busy, r_stop_det;
  logic [7:0]  r_rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high in both this and the previous sample, so an SDA edge
  // coinciding with an SCL edge is never taken as START/STOP.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_sr       <= 7'd0;
      r_tx_sr    <= 7'd0;
      r_rw       <= 1'b0;
      r_ack_ph   <= 1'b0;
      r_first    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_rx_first <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_stop_det <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_stop_det <= 1'b0;
      if (w_stop) begin
        r_state    <= S_IDLE;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_stop_det <= 1'b1;
      end else if (w_start) begin
        r_state  <= S_ADDR;
        r_sda_oe <= 1'b0;
        r_cnt    <= 3'd0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_ADDR: begin
            if (w_scl_rise) begin
              r_sr  <= {r_sr[5:0], w_sda};
              r_cnt <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                if (r_sr == ADDR) begin
                  r_busy   <= 1'b1;
                  r_rw     <= w_sda;
                  r_tx_req <= w_sda;
                  r_first  <= 1'b1;
                  r_ack_ph <= 1'b0;
                  r_state  <= S_ADDR_ACK;
                end else begin
                  r_state <= S_IDLE;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_ph) begin
                r_sda_oe <= 1'b1;
                r_ack_ph <= 1'b1;
              end else if (!r_rw) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_RX;
              end else begin
                r_tx_sr  <= tx_data[6:0];
                r_sda_oe <= ~tx_data[7];
                r_cnt    <= 3'd0;
                r_state  <= S_TX;
              end
            end
          end
          S_RX: begin
            if (w_scl_rise) begin
              r_sr  <= {r_sr[5:0], w_sda};
              r_cnt <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                r_rx_data  <= {r_sr, w_sda};
                r_rx_valid <= 1'b1;
                r_rx_first <= r_first;
                r_first    <= 1'b0;
                r_ack_ph   <= 1'b0;
                r_state    <= S_RX_ACK;
              end
            end
          end
          S_RX_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_ph) begin
                r_sda_oe <= 1'b1;
                r_ack_ph <= 1'b1;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_RX;
              end
            end
          end
          S_TX: begin
            if (w_scl_fall) begin
              r_cnt <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                r_sda_oe <= 1'b0;
                r_ack_ph <= 1'b0;
                r_state  <= S_TX_ACK;
              end else begin
                r_sda_oe <= ~r_tx_sr[6];
                r_tx_sr  <= {r_tx_sr[5:0], 1'b0};
              end
            end
          end
          S_TX_ACK: begin
            if (w_scl_rise && !r_ack_ph) begin
              if (!w_sda) begin
                r_tx_req <= 1'b1;
                r_ack_ph <= 1'b1;
              end else begin
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
                r_state  <= S_IDLE;
              end
            end else if (w_scl_fall && r_ack_ph) begin
              r_tx_sr  <= tx_data[6:0];
              r_sda_oe <= ~tx_data[7];
              r_cnt    <= 3'd0;
              r_state  <= S_TX;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_first = r_rx_first;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;
  assign stop_det = r_stop_det;

endmodule
